// File: rtl/processor_pkg.sv
// processor_pkg: instruction encodings, ALU operations and decoded control word
package processor_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] F_JR = 6'b001000;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI} alu_op_t;
   typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_t;
   typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_HI, WB_LO, WB_PC4} wb_t;
   typedef struct packed {
      logic reg_we;
      logic mem_we;
      logic hilo_we;
      logic alu_imm;
      logic imm_zext;
      logic beq;
      logic bltz;
      logic jump;
      logic jreg;
      dst_t dst;
      wb_t wb;
      alu_op_t alu_op;
   } ctrl_t;
   function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
      return op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b :
             op == ALU_OR ? a | b :
             op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} :
             op == ALU_SLTU ? {31'b0, a < b} :
             op == ALU_LUI ? {b[15:0], 16'b0} : a + b;
   endfunction
endpackage

// File: rtl/processor_if.sv
// processor_if: instruction fetch and data memory bus between core and memories
interface processor_if;
   logic [31:0] iaddr, instr, daddr, dwdata, drdata;
   logic dwe;
   modport master (output iaddr, daddr, dwdata, dwe, input instr, drdata);
   modport slave (input iaddr, daddr, dwdata, dwe, output instr, drdata);
endinterface

// File: rtl/processor_ctrl.sv
// processor_ctrl: decodes opcode/funct into the datapath control word
module processor_ctrl import processor_pkg::*; (
   input logic reset,
   input logic [5:0] op,
   input logic [5:0] fn,
   input logic [4:0] rt,
   output ctrl_t ctrl
);
   // decode; anything unrecognised leaves the all-zero NOP word, reset masks every write
   always_comb begin
      ctrl = '0;
      case (op)
         OP_RTYPE: begin
            ctrl.dst = DST_RD;
            ctrl.reg_we = fn inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU, F_MFHI, F_MFLO};
            ctrl.alu_op = (fn == F_SUB || fn == F_SUBU) ? ALU_SUB : fn == F_AND ? ALU_AND :
                          fn == F_OR ? ALU_OR : fn == F_SLT ? ALU_SLT : fn == F_SLTU ? ALU_SLTU : ALU_ADD;
            ctrl.wb = fn == F_MFHI ? WB_HI : fn == F_MFLO ? WB_LO : WB_ALU;
            ctrl.hilo_we = fn == F_MULTU;
            ctrl.jreg = fn == F_JR;
         end
         OP_REGIMM: ctrl.bltz = rt == 5'd0;
         OP_J: ctrl.jump = 1'b1;
         OP_JAL: begin
            ctrl.jump = 1'b1;
            ctrl.reg_we = 1'b1;
            ctrl.dst = DST_RA;
            ctrl.wb = WB_PC4;
         end
         OP_BEQ: ctrl.beq = 1'b1;
         OP_ADDI, OP_ORI, OP_LUI, OP_LW: begin
            ctrl.reg_we = 1'b1;
            ctrl.alu_imm = 1'b1;
            ctrl.imm_zext = op == OP_ORI;
            ctrl.alu_op = op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
            ctrl.wb = op == OP_LW ? WB_MEM : WB_ALU;
         end
         OP_SW: begin
            ctrl.mem_we = 1'b1;
            ctrl.alu_imm = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         ctrl.reg_we = 1'b0;
         ctrl.mem_we = 1'b0;
         ctrl.hilo_we = 1'b0;
      end
   end
endmodule

// File: rtl/processor_dmem.sv
// processor_dmem: word-addressed data RAM, combinational read, write at the edge
module processor_dmem #(parameter int WORDS = 64) (
   input logic clk,
   processor_if.slave bus
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] ram [0:WORDS-1];
   logic unused_addr;
   assign unused_addr = ^{bus.daddr[31:AW+2], bus.daddr[1:0]};
   // store word; the controller already masks dwe during reset
   always_ff @(posedge clk) if (bus.dwe) ram[bus.daddr[AW+1:2]] <= bus.dwdata;
   assign bus.drdata = ram[bus.daddr[AW+1:2]];
endmodule

// File: rtl/processor_dp.sv
// processor_dp: PC, HI/LO, register file, ALU and write-back muxing
module processor_dp import processor_pkg::*; (
   input logic clk,
   input logic reset,
   input ctrl_t ctrl,
   processor_if.master bus
);
   logic [31:0] pc_d, pc_q, hi_d, hi_q, lo_d, lo_q;
   logic [31:0] a, b, ext, y, wd, pc4, pc_br;
   logic [63:0] prod;
   logic [15:0] imm;
   logic [4:0] rt, rd, wa;
   assign imm = bus.instr[15:0];
   assign rt = bus.instr[20:16];
   assign rd = bus.instr[15:11];
   assign ext = ctrl.imm_zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
   assign y = alu(ctrl.alu_op, a, ctrl.alu_imm ? ext : b);
   assign pc4 = pc_q + 32'd4;
   assign pc_br = pc4 + {ext[29:0], 2'b00};
   assign prod = {32'b0, a} * {32'b0, b};
   assign wa = ctrl.dst == DST_RD ? rd : ctrl.dst == DST_RA ? 5'd31 : rt;
   assign wd = ctrl.wb == WB_MEM ? bus.drdata : ctrl.wb == WB_HI ? hi_q : ctrl.wb == WB_LO ? lo_q :
               ctrl.wb == WB_PC4 ? pc4 : y;
   regfile gpr (.clk(clk), .we(ctrl.reg_we), .ra1(bus.instr[25:21]), .ra2(rt), .wa(wa), .wd(wd), .rd1(a), .rd2(b));
   // next PC selection and multu result
   always_comb begin
      pc_d = ctrl.jreg ? a : ctrl.jump ? {pc4[31:28], bus.instr[25:0], 2'b00} :
             ((ctrl.beq && a == b) || (ctrl.bltz && a[31])) ? pc_br : pc4;
      {hi_d, lo_d} = ctrl.hilo_we ? prod : {hi_q, lo_q};
   end
   // architectural state; reset restarts at address 0 with HI/LO cleared
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= 32'd0;
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         pc_q <= pc_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
   assign bus.iaddr = pc_q;
   assign bus.daddr = y;
   assign bus.dwdata = b;
   assign bus.dwe = ctrl.mem_we;
endmodule

// File: rtl/processor_imem.sv
// processor_imem: word-addressed instruction ROM, loaded externally
module processor_imem #(parameter int WORDS = 64) (
   processor_if.slave bus
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] INSTRROM [0:WORDS-1];
   logic unused_addr;
   assign unused_addr = ^{bus.iaddr[31:AW+2], bus.iaddr[1:0]};
   assign bus.instr = INSTRROM[bus.iaddr[AW+1:2]];
endmodule

// File: rtl/processor_mips.sv
// processor_mips: single-cycle core, controller plus datapath
module processor_mips import processor_pkg::*; (
   input logic clk,
   input logic reset,
   processor_if.master bus
);
   ctrl_t ctrl;
   processor_ctrl ctl (.reset(reset), .op(bus.instr[31:26]), .fn(bus.instr[5:0]), .rt(bus.instr[20:16]), .ctrl(ctrl));
   processor_dp dp (.clk(clk), .reset(reset), .ctrl(ctrl), .bus(bus));
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 GPRs, two combinational reads, one write; $0 reads as zero
module regfile (
   input logic clk,
   input logic we,
   input logic [4:0] ra1,
   input logic [4:0] ra2,
   input logic [4:0] wa,
   input logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] registers [1:31];
   // write port; $0 has no storage so writes to it are dropped
   always_ff @(posedge clk) if (we && wa != 5'd0) registers[wa] <= wd;
   assign rd1 = ra1 == 5'd0 ? 32'd0 : registers[ra1];
   assign rd2 = ra2 == 5'd0 ? 32'd0 : registers[ra2];
endmodule

// File: rtl/processor.sv
// processor: single-cycle MIPS subset with separate instruction ROM and data RAM
module processor #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input logic clk,
   input logic reset
);
   processor_if bus ();
   processor_mips mips (.clk(clk), .reset(reset), .bus(bus));
   processor_imem #(.WORDS(IMEM_WORDS)) imem (.bus(bus));
   processor_dmem #(.WORDS(DMEM_WORDS)) dmem (.clk(clk), .bus(bus));
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed programs with a queue of expected architectural state
module tb_processor;
   import processor_pkg::*;
   typedef struct { string tag; int idx; logic [31:0] exp; } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic [31:0] prog[$];

   always #5 clk = ~clk;

   processor #(.IMEM_WORDS(64), .DMEM_WORDS(64)) proc (.clk(clk), .reset(reset));

   function automatic logic [31:0] rtype(logic [5:0] fn, int s, int t, int d);
      return {OP_RTYPE, 5'(s), 5'(t), 5'(d), 5'd0, fn};
   endfunction
   function automatic logic [31:0] itype(logic [5:0] op, int s, int t, int imm);
      return {op, 5'(s), 5'(t), 16'(imm)};
   endfunction
   function automatic logic [31:0] jtype(logic [5:0] op, int tgt);
      return {op, 26'(tgt)};
   endfunction

   // idx 1..31 = GPR, 32 = PC, 33 = HI, 34 = LO
   function automatic logic [31:0] obs(int k);
      if (k == 32) return proc.mips.dp.pc_q;
      if (k == 33) return proc.mips.dp.hi_q;
      if (k == 34) return proc.mips.dp.lo_q;
      return proc.mips.dp.gpr.registers[k];
   endfunction

   task automatic exp_push(string tag, int idx, logic [31:0] v);
      sb.push_back('{tag, idx, v});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (obs(e.idx) === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs(e.idx), e.exp);
         end
      end
   endtask

   task automatic run(int n);
      repeat (n) @(negedge clk);
   endtask

   // hold reset for one edge while the ROM is replaced; a self-loop ends the program
   task automatic load(string name);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 64; i++) proc.imem.INSTRROM[i] = 32'h0;
      foreach (prog[i]) proc.imem.INSTRROM[i] = prog[i];
      proc.imem.INSTRROM[prog.size()] = jtype(OP_J, prog.size());
      @(negedge clk);
      exp_push({name, "_rst_pc"}, 32, 32'h0);
      exp_push({name, "_rst_hi"}, 33, 32'h0);
      exp_push({name, "_rst_lo"}, 34, 32'h0);
      drain();
      reset = 1'b0;
   endtask

   task automatic preload();
      prog = {};
      for (int k = 1; k < 32; k++) begin
         prog.push_back(itype(OP_LUI, 0, k, 'hcafe));
         prog.push_back(itype(OP_ORI, k, k, 'hbabe));
      end
      load("pre");
      run(64);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // lui/ori composition; unlisted opcode and funct leave state alone
      preload();
      prog = {itype(OP_LUI, 0, 1, 'h1234), itype(OP_ORI, 1, 1, 'h5678),
              itype(6'b111111, 0, 18, 5), rtype(6'b000000, 1, 1, 19), rtype(6'b111111, 1, 1, 20)};
      load("t1");
      run(6);
      exp_push("t1_r1", 1, 32'h12345678);
      for (int k = 2; k < 32; k++) exp_push($sformatf("t1_r%0d", k), k, 32'hcafebabe);
      drain();

      // bltz taken and not taken; REGIMM with rt != 0 is a NOP
      preload();
      prog = {itype(OP_ADDI, 0, 2, -5), itype(OP_REGIMM, 2, 0, 1), itype(OP_ADDI, 0, 3, 1),
              itype(OP_ADDI, 0, 4, 2), itype(OP_REGIMM, 4, 0, 1), itype(OP_ADDI, 0, 8, 3),
              itype(OP_REGIMM, 2, 1, 1), itype(OP_ADDI, 0, 9, 4)};
      load("t2");
      run(8);
      exp_push("t2_r2", 2, 32'hfffffffb);
      exp_push("t2_r3_skipped", 3, 32'hcafebabe);
      exp_push("t2_r4", 4, 32'h2);
      exp_push("t2_r8", 8, 32'h3);
      exp_push("t2_r9", 9, 32'h4);
      drain();

      // multu/mfhi/mflo, ALU ops, wraparound, memory, beq, extension modes
      prog = {itype(OP_ADDI, 0, 1, -1), itype(OP_ADDI, 0, 2, 2), rtype(F_MULTU, 1, 2, 0),
              rtype(F_MFHI, 0, 0, 3), rtype(F_MFLO, 0, 0, 4), rtype(F_SLT, 1, 2, 5),
              rtype(F_SLTU, 1, 2, 6), rtype(F_SUB, 2, 1, 7), rtype(F_SUBU, 1, 2, 8),
              rtype(F_AND, 1, 2, 9), itype(OP_ADDI, 0, 16, 16), rtype(F_OR, 2, 16, 10),
              rtype(F_ADD, 1, 2, 11), rtype(F_ADDU, 1, 1, 12), itype(OP_LUI, 0, 13, 'h7fff),
              itype(OP_ORI, 13, 13, 'hffff), itype(OP_ADDI, 13, 14, 1), itype(OP_SW, 16, 1, -4),
              itype(OP_SW, 0, 2, 8), itype(OP_LW, 0, 15, 8), itype(OP_LW, 0, 17, 12),
              itype(OP_BEQ, 1, 2, 1), itype(OP_ADDI, 0, 18, 'h55), itype(OP_ORI, 0, 19, 'h8000),
              itype(OP_BEQ, 2, 2, 1), itype(OP_ADDI, 0, 20, 1), itype(OP_ADDI, 0, 21, -32768)};
      load("t3");
      run(30);
      exp_push("t3_hi", 33, 32'h1);
      exp_push("t3_lo", 34, 32'hfffffffe);
      exp_push("t3_mfhi", 3, 32'h1);
      exp_push("t3_mflo", 4, 32'hfffffffe);
      exp_push("t3_slt", 5, 32'h1);
      exp_push("t3_sltu", 6, 32'h0);
      exp_push("t3_sub", 7, 32'h3);
      exp_push("t3_subu", 8, 32'hfffffffd);
      exp_push("t3_and", 9, 32'h2);
      exp_push("t3_or", 10, 32'h12);
      exp_push("t3_add_wrap", 11, 32'h1);
      exp_push("t3_addu", 12, 32'hfffffffe);
      exp_push("t3_lui_ori", 13, 32'h7fffffff);
      exp_push("t3_addi_wrap", 14, 32'h80000000);
      exp_push("t3_lw8", 15, 32'h2);
      exp_push("t3_lw12", 17, 32'hffffffff);
      exp_push("t3_beq_not_taken", 18, 32'h55);
      exp_push("t3_ori_zext", 19, 32'h00008000);
      exp_push("t3_beq_taken_skip", 20, 32'hcafebabe);
      exp_push("t3_addi_sext", 21, 32'hffff8000);
      drain();

      // jal / jr
      prog = {jtype(OP_JAL, 3), itype(OP_ADDI, 0, 6, 9), 32'h0, itype(OP_ADDI, 0, 5, 7), rtype(F_JR, 31, 0, 0)};
      load("t4");
      run(6);
      exp_push("t4_r31", 31, 32'h4);
      exp_push("t4_r5", 5, 32'h7);
      exp_push("t4_r6", 6, 32'h9);
      exp_push("t4_pc", 32, 32'h10);
      drain();

      // Fibonacci loop; write to $0 must not stick
      prog = {itype(OP_ADDI, 0, 1, 0), itype(OP_ADDI, 0, 2, 1), itype(OP_ADDI, 0, 3, 4),
              itype(OP_ADDI, 0, 0, 5), rtype(F_ADD, 0, 0, 7), itype(OP_BEQ, 3, 0, 5),
              rtype(F_ADD, 1, 2, 4), itype(OP_ADDI, 2, 1, 0), itype(OP_ADDI, 4, 2, 0),
              itype(OP_ADDI, 3, 3, -1), jtype(OP_J, 5)};
      load("t5");
      run(32);
      exp_push("t5_fib_a", 1, 32'h3);
      exp_push("t5_fib_b", 2, 32'h5);
      exp_push("t5_count", 3, 32'h0);
      exp_push("t5_fib_t", 4, 32'h5);
      exp_push("t5_r0_read", 7, 32'h0);
      exp_push("t5_pc", 32, 32'h2c);
      drain();

      // reset for one edge mid-loop
      prog = {itype(OP_ADDI, 0, 1, -1), itype(OP_ADDI, 0, 2, 2), rtype(F_MULTU, 1, 2, 0),
              itype(OP_ADDI, 0, 9, 0), itype(OP_ADDI, 9, 9, 1), jtype(OP_J, 4)};
      load("t6");
      run(10);
      exp_push("t6_pre_r9", 9, 32'h3);
      exp_push("t6_pre_hi", 33, 32'h1);
      exp_push("t6_pre_pc", 32, 32'h10);
      drain();
      reset = 1'b1;
      @(negedge clk);
      exp_push("t6_rst_pc", 32, 32'h0);
      exp_push("t6_rst_hi", 33, 32'h0);
      exp_push("t6_rst_lo", 34, 32'h0);
      exp_push("t6_rst_r9_kept", 9, 32'h3);
      exp_push("t6_rst_r1_kept", 1, 32'hffffffff);
      drain();
      reset = 1'b0;
      run(4);
      exp_push("t6_rerun_r9", 9, 32'h0);
      exp_push("t6_rerun_hi", 33, 32'h1);
      exp_push("t6_rerun_lo", 34, 32'hfffffffe);
      exp_push("t6_rerun_pc", 32, 32'h10);
      drain();
      run(3);
      exp_push("t6_loop_r9", 9, 32'h2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
